and_gate: RTL and testbench

- Bitwise 2-input AND primitive for the ALU logic-op slice.
- `out` is purely combinational, so `out = a & b` holds at any time, with or without clock activity.
- A registered side-path captures the result with a valid flag, zero/all-ones flags and a population count, for pipelined ALU consumers.
- One clock domain: `clk`, with asynchronous active-high reset `rst`.

---
 rtl/and_gate_pkg.sv | 16 +
 rtl/and_gate_popcnt.sv | 32 +++
 rtl/and_gate.sv | 76 +++++++
 tb/tb_and_gate.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/and_gate_pkg.sv
// Shared constants and a reference popcount helper for the and_gate logic-op slice.
package and_gate_pkg;

  localparam int DEFAULT_WIDTH = 1;

  // Counts the ones among the low w bits of v; bits at or above w are ignored.
  function automatic int popcount(logic [63:0] v, int w);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (i < w && v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/and_gate_popcnt.sv
// Combinational population count built as a balanced binary adder tree.
module and_gate_popcnt #(
  parameter int WIDTH = 1,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] v,
  output logic [CNT_W-1:0] cnt
);

  // Leaves are padded up to a power of two; nodes are stored heap-style, root at index 0.
  localparam int LEVELS = $clog2(WIDTH);
  localparam int LEAVES = 1 << LEVELS;
  localparam int NODES  = 2 * LEAVES - 1;

  logic [CNT_W-1:0] node [NODES];

  for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
    if (i < WIDTH) begin : g_real
      assign node[LEAVES-1+i] = CNT_W'(v[i]);
    end else begin : g_pad
      assign node[LEAVES-1+i] = '0;
    end
  end

  // Every partial sum is bounded by WIDTH, so CNT_W bits never overflow.
  for (genvar j = 0; j < LEAVES - 1; j++) begin : g_add
    assign node[j] = node[2*j+1] + node[2*j+2];
  end

  assign cnt = node[0];

endmodule

// File: rtl/and_gate.sv
// Bitwise AND with a zero-latency output plus a registered side-path carrying flags and popcount.
module and_gate
  import and_gate_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid,
  output logic             zero_q,
  output logic             ones_q,
  output logic [CNT_W-1:0] popcnt_q
);

  logic [WIDTH-1:0] and_w;
  logic [CNT_W-1:0] pop_w;

  assign and_w = a & b;
  assign out   = and_w;

  and_gate_popcnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_popcnt (
    .v   (and_w),
    .cnt (pop_w)
  );

  // Handshake: in_valid is a single-cycle capture strobe with no ready (never stalls);
  // out_valid is high for exactly the cycle after each sampled in_valid, data holds otherwise.
  logic [WIDTH-1:0] out_d;
  logic             zero_d;
  logic             ones_d;
  logic [CNT_W-1:0] popcnt_d;
  logic             valid_d;
  logic             valid_q;

  always_comb begin
    out_d    = out_q;
    zero_d   = zero_q;
    ones_d   = ones_q;
    popcnt_d = popcnt_q;
    valid_d  = in_valid;
    if (in_valid) begin
      out_d    = and_w;
      zero_d   = ~|and_w;
      ones_d   = &and_w;
      popcnt_d = pop_w;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q    <= '0;
      zero_q   <= 1'b0;
      ones_q   <= 1'b0;
      popcnt_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      out_q    <= out_d;
      zero_q   <= zero_d;
      ones_q   <= ones_d;
      popcnt_q <= popcnt_d;
      valid_q  <= valid_d;
    end
  end

  assign out_valid = valid_q;

endmodule

// File: tb/tb_and_gate.sv
// Self-checking bench for and_gate at WIDTH 1, 8 and 13.
module tb_and_gate;

  // ---------------- clock / reset ----------------
  logic clk8 = 1'b0;
  always #5 clk8 = ~clk8;

  logic clk1, rst1, rst8;

  // ---------------- DUT signals ----------------
  logic       a1, b1, in_valid1, out1, out_q1, out_valid1, zero_q1, ones_q1, popcnt_q1;

  logic       in_valid8, out_valid8, zero_q8, ones_q8;
  logic [7:0] a8, b8, out8, out_q8;
  logic [3:0] popcnt_q8;

  logic        in_valid13, out_valid13, zero_q13, ones_q13;
  logic [12:0] a13, b13, out13, out_q13;
  logic [3:0]  popcnt_q13;

  and_gate #(.WIDTH(1)) u_dut1 (
    .clk(clk1), .rst(rst1), .a(a1), .b(b1), .out(out1), .in_valid(in_valid1),
    .out_q(out_q1), .out_valid(out_valid1), .zero_q(zero_q1), .ones_q(ones_q1),
    .popcnt_q(popcnt_q1)
  );

  and_gate #(.WIDTH(8)) u_dut8 (
    .clk(clk8), .rst(rst8), .a(a8), .b(b8), .out(out8), .in_valid(in_valid8),
    .out_q(out_q8), .out_valid(out_valid8), .zero_q(zero_q8), .ones_q(ones_q8),
    .popcnt_q(popcnt_q8)
  );

  and_gate #(.WIDTH(13)) u_dut13 (
    .clk(clk8), .rst(rst8), .a(a13), .b(b13), .out(out13), .in_valid(in_valid13),
    .out_q(out_q13), .out_valid(out_valid13), .zero_q(zero_q13), .ones_q(ones_q13),
    .popcnt_q(popcnt_q13)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [13:0] exp_q[$];    // {out, zero, ones, popcnt} for WIDTH=8
  logic [19:0] exp13_q[$];  // {valid, out, zero, ones, popcnt} for WIDTH=13

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;
    logic       zero;
    logic       ones;
    logic [3:0] pop;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_cmp8(input string tag);
    logic [13:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_queue: got empty expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, out_valid8, 1'b1);
      chk({tag, "_out_q"}, out_q8, e[13:6]);
      chk({tag, "_zero"}, zero_q8, e[5]);
      chk({tag, "_ones"}, ones_q8, e[4]);
      chk({tag, "_pop"}, popcnt_q8, e[3:0]);
    end
  endtask

  task automatic chk_zero8(input string tag);
    chk({tag, "_out_q"}, out_q8, 8'h00);
    chk({tag, "_valid"}, out_valid8, 1'b0);
    chk({tag, "_zero"}, zero_q8, 1'b0);
    chk({tag, "_ones"}, ones_q8, 1'b0);
    chk({tag, "_pop"}, popcnt_q8, 4'd0);
  endtask

  task automatic pulse_clk1();
    #4 clk1 = 1'b1;
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  ab;
    logic [12:0] m13, last_out13;
    logic        last_zero13, last_ones13, v13;
    logic [3:0]  last_pop13, cnt13;
    logic [19:0] e13;

    tbl[0] = '{8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1, 4'd8};
    tbl[1] = '{8'h0F, 8'h0F, 8'h0F, 1'b0, 1'b0, 4'd4};
    tbl[2] = '{8'h81, 8'hFF, 8'h81, 1'b0, 1'b0, 4'd2};
    tbl[3] = '{8'h7F, 8'hFE, 8'h7E, 1'b0, 1'b0, 4'd6};
    tbl[4] = '{8'hAA, 8'h55, 8'h00, 1'b1, 1'b0, 4'd0};
    tbl[5] = '{8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 4'd2};

    clk1 = 1'b0; rst1 = 1'b1; a1 = 1'b0; b1 = 1'b0; in_valid1 = 1'b0;
    rst8 = 1'b1; a8 = 8'hF0; b8 = 8'h3C; in_valid8 = 1'b1;
    a13 = '0; b13 = '0; in_valid13 = 1'b0;

    // WIDTH=1: reset state, then combinational truth table with clk1 idle
    #1;
    chk("w1_rst_out_q", out_q1, 1'b0);
    chk("w1_rst_valid", out_valid1, 1'b0);
    chk("w1_rst_zero", zero_q1, 1'b0);
    chk("w1_rst_ones", ones_q1, 1'b0);
    chk("w1_rst_pop", popcnt_q1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      a1 = ab[1];
      b1 = ab[0];
      #1 chk("w1_comb", out1, (i == 3) ? 1'b1 : 1'b0);
      #9;
    end

    // WIDTH=1 registered path: zero_q == ~out_q, ones_q == out_q
    rst1 = 1'b0;
    a1 = 1'b1; b1 = 1'b1; in_valid1 = 1'b1;
    pulse_clk1();
    chk("w1_cap1_out_q", out_q1, 1'b1);
    chk("w1_cap1_ones", ones_q1, 1'b1);
    chk("w1_cap1_zero", zero_q1, 1'b0);
    chk("w1_cap1_pop", popcnt_q1, 1'b1);
    chk("w1_cap1_valid", out_valid1, 1'b1);
    #4 clk1 = 1'b0;
    a1 = 1'b1; b1 = 1'b0;
    pulse_clk1();
    chk("w1_cap0_out_q", out_q1, 1'b0);
    chk("w1_cap0_ones", ones_q1, 1'b0);
    chk("w1_cap0_zero", zero_q1, 1'b1);
    chk("w1_cap0_pop", popcnt_q1, 1'b0);
    #4 clk1 = 1'b0;
    in_valid1 = 1'b0; a1 = 1'b1; b1 = 1'b1;
    pulse_clk1();
    chk("w1_hold_valid", out_valid1, 1'b0);
    chk("w1_hold_out_q", out_q1, 1'b0);
    chk("w1_hold_zero", zero_q1, 1'b1);
    #4 clk1 = 1'b0;

    // WIDTH=8: reset held with in_valid=1 while the clock runs
    repeat (3) @(negedge clk8);
    chk_zero8("w8_rst");
    chk("w8_rst_comb", out8, 8'h30);

    // WIDTH=8 table, back-to-back captures
    rst8 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a8 = tbl[i].a;
      b8 = tbl[i].b;
      in_valid8 = 1'b1;
      #1 chk("w8_tbl_comb", out8, tbl[i].out);
      exp_q.push_back({tbl[i].out, tbl[i].zero, tbl[i].ones, tbl[i].pop});
      @(posedge clk8);
      @(negedge clk8);
      pop_cmp8("w8_tbl");
    end

    // drop in_valid: out_valid falls, data holds 8'h30
    in_valid8 = 1'b0; a8 = 8'h12; b8 = 8'h34;
    @(posedge clk8);
    @(negedge clk8);
    chk("w8_hold_valid", out_valid8, 1'b0);
    chk("w8_hold_out_q", out_q8, 8'h30);
    chk("w8_hold_zero", zero_q8, 1'b0);
    chk("w8_hold_pop", popcnt_q8, 4'd2);
    chk("w8_hold_comb", out8, 8'h10);

    // capture, then assert reset between edges
    a8 = 8'hFF; b8 = 8'hFF; in_valid8 = 1'b1;
    @(posedge clk8);
    #1;
    chk("w8_pre_rst_out_q", out_q8, 8'hFF);
    chk("w8_pre_rst_valid", out_valid8, 1'b1);
    #1 rst8 = 1'b1;
    #1;
    chk_zero8("w8_async_rst");
    chk("w8_async_comb", out8, 8'hFF);
    a8 = 8'h5A; b8 = 8'hF3;
    #1 chk("w8_async_comb2", out8, 8'h52);
    @(posedge clk8);
    @(negedge clk8);
    chk_zero8("w8_rst_held");

    // first capture after reset release
    rst8 = 1'b0;
    a8 = 8'h0C; b8 = 8'h0A;
    exp_q.push_back({8'h08, 1'b0, 1'b0, 4'd1});
    @(posedge clk8);
    @(negedge clk8);
    pop_cmp8("w8_post_rst");
    in_valid8 = 1'b0;

    // WIDTH=13 random stream against a reference model
    last_out13 = '0; last_zero13 = 1'b0; last_ones13 = 1'b0; last_pop13 = '0;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        a13 = 13'h1FFF; b13 = 13'h1FFF;
      end else begin
        a13 = 13'($urandom_range(0, 8191));
        b13 = 13'($urandom_range(0, 8191));
      end
      v13 = ($urandom_range(0, 3) != 0);
      in_valid13 = v13;
      if (v13) begin
        m13 = '0;
        for (int k = 0; k < 13; k++) m13[k] = a13[k] && b13[k];
        cnt13 = '0;
        for (int k = 0; k < 13; k++) if (m13[k]) cnt13 = cnt13 + 4'd1;
        last_out13 = m13;
        last_zero13 = (cnt13 == 4'd0);
        last_ones13 = (cnt13 == 4'd13);
        last_pop13 = cnt13;
      end
      exp13_q.push_back({v13, last_out13, last_zero13, last_ones13, last_pop13});
      @(posedge clk8);
      @(negedge clk8);
      if (exp13_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL w13_queue: got empty expected entry");
      end else begin
        e13 = exp13_q.pop_front();
        chk("w13_valid", out_valid13, e13[19]);
        chk("w13_out_q", out_q13, e13[18:6]);
        chk("w13_zero", zero_q13, e13[5]);
        chk("w13_ones", ones_q13, e13[4]);
        chk("w13_pop", popcnt_q13, e13[3:0]);
      end
    end
    in_valid13 = 1'b0;

    chk("sb_drained", 64'(exp_q.size() + exp13_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
